// File: rtl/game_flow_ctrl.sv
// Escape-game sequencer: screen state, per-stage progress, stage unlocks and menu cursor.
// Every output comes straight from a register; events become visible one clock later.
module game_flow_ctrl #(
  parameter int KEYS_NEEDED   = 3,
  parameter int LIFE_INIT     = 3,
  parameter int INVULN_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_enter,
  input  logic       key_pickup,
  input  logic       light_found,
  input  logic       door_reached,
  input  logic       hazard_hit,
  output logic [3:0] state,
  output logic [1:0] key_find,
  output logic [1:0] life,
  output logic [1:0] todo,
  output logic [3:0] play_valid,
  output logic [1:0] cursor,
  output logic       invuln
);

  localparam int CW = (INVULN_CYCLES < 2) ? 1 : $clog2(INVULN_CYCLES + 1);

  typedef enum logic [3:0] {
    S_TITLE    = 4'd0,
    S_STAFF    = 4'd1,
    S_STAGE1   = 4'd2,
    S_SUCCESS1 = 4'd3,
    S_STAGE2   = 4'd4,
    S_SUCCESS2 = 4'd5,
    S_STAGE3   = 4'd6,
    S_SUCCESS3 = 4'd7,
    S_FAIL     = 4'd8
  } state_t;

  localparam logic [1:0] T_NONE  = 2'd0;
  localparam logic [1:0] T_KEY   = 2'd1;
  localparam logic [1:0] T_LIGHT = 2'd2;
  localparam logic [1:0] T_DOOR  = 2'd3;

  state_t          r_state, r_last, w_nxt;
  logic [1:0]      r_key, r_life, r_todo, r_cursor;
  logic [3:0]      r_pv;
  logic [CW-1:0]   r_cnt;
  logic            r_invuln;
  logic            w_in_stage, w_to_stage, w_hit, w_fatal, w_door;

  // Title menu: item k<3 is stage k+1 (selectable only when unlocked), item 3 is staff.
  function automatic logic [1:0] f_step(input logic [1:0] cur, input logic up,
                                        input logic [3:0] pv);
    logic [1:0] c;
    c      = cur;
    f_step = cur;
    for (int i = 0; i < 3; i++) begin
      c = up ? c - 2'd1 : c + 2'd1;
      if (c == 2'd3 || pv[{1'b0, c} + 3'd1]) return c;
    end
  endfunction

  always_comb begin
    w_in_stage = (r_state == S_STAGE1) || (r_state == S_STAGE2) || (r_state == S_STAGE3);
    w_hit      = (r_state == S_STAGE3) && hazard_hit && !r_invuln;
    w_fatal    = w_hit && (r_life <= 2'd1);
    w_door     = w_in_stage && door_reached && (r_todo == T_DOOR);
    w_nxt      = r_state;
    case (r_state)
      S_TITLE: if (btn_enter) begin
        case (r_cursor)
          2'd0:    w_nxt = S_STAGE1;
          2'd1:    if (r_pv[2]) w_nxt = S_STAGE2;
          2'd2:    if (r_pv[3]) w_nxt = S_STAGE3;
          default: w_nxt = S_STAFF;
        endcase
      end
      S_STAFF:    if (btn_enter) w_nxt = S_TITLE;
      S_STAGE1, S_STAGE2, S_STAGE3: begin
        if (w_fatal)     w_nxt = S_FAIL;
        else if (w_door) w_nxt = state_t'(r_state + 4'd1);
      end
      S_SUCCESS1: if (btn_enter) w_nxt = (r_cursor == 2'd0) ? S_STAGE2 : S_TITLE;
      S_SUCCESS2: if (btn_enter) w_nxt = (r_cursor == 2'd0) ? S_STAGE3 : S_TITLE;
      S_SUCCESS3: if (btn_enter) w_nxt = S_STAFF;
      S_FAIL:     if (btn_enter) w_nxt = (r_cursor == 2'd0) ? r_last : S_TITLE;
      default:    w_nxt = S_TITLE;
    endcase
    w_to_stage = (w_nxt != r_state) &&
                 ((w_nxt == S_STAGE1) || (w_nxt == S_STAGE2) || (w_nxt == S_STAGE3));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_TITLE;
      r_last   <= S_STAGE1;
      r_key    <= 2'd0;
      r_life   <= 2'(LIFE_INIT);
      r_todo   <= T_NONE;
      r_pv     <= 4'b0010;
      r_cursor <= 2'd0;
      r_cnt    <= '0;
      r_invuln <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (r_cnt != '0) begin
        r_cnt    <= r_cnt - CW'(1);
        r_invuln <= (r_cnt != CW'(1));
      end
      if (w_nxt == r_state) begin
        if (w_in_stage) begin
          if (w_hit) begin
            r_life   <= r_life - 2'd1;
            r_cnt    <= CW'(INVULN_CYCLES);
            r_invuln <= 1'b1;
          end
          if (light_found && r_todo == T_LIGHT) r_todo <= T_KEY;
          if (key_pickup && r_todo == T_KEY) begin
            if (r_key >= 2'(KEYS_NEEDED - 1)) begin
              r_key  <= 2'(KEYS_NEEDED);
              r_todo <= T_DOOR;
            end else begin
              r_key <= r_key + 2'd1;
            end
          end
        end else if (!btn_enter && (btn_up ^ btn_down)) begin
          if (r_state == S_TITLE)
            r_cursor <= f_step(r_cursor, btn_up, r_pv);
          else if (r_state == S_SUCCESS1 || r_state == S_SUCCESS2 || r_state == S_FAIL)
            r_cursor <= {1'b0, ~r_cursor[0]};
        end
      end else begin
        r_cursor <= 2'd0;
        r_cnt    <= '0;
        r_invuln <= 1'b0;
        if (w_fatal) r_life <= 2'd0;
        if (w_door && !w_fatal) r_todo <= T_NONE;
        if (w_nxt == S_SUCCESS1) r_pv[2] <= 1'b1;
        if (w_nxt == S_SUCCESS2) r_pv[3] <= 1'b1;
        if (w_to_stage) begin
          r_key  <= 2'd0;
          r_life <= 2'(LIFE_INIT);
          r_todo <= (w_nxt == S_STAGE2) ? T_LIGHT : T_KEY;
          r_last <= w_nxt;
        end
      end
    end
  end

  assign state      = r_state;
  assign key_find   = r_key;
  assign life       = r_life;
  assign todo       = r_todo;
  assign play_valid = r_pv;
  assign cursor     = r_cursor;
  assign invuln     = r_invuln;

endmodule
